dsp_result_capture: RTL

DSP_RESULT_CAPTURE -- requirements
Module: dsp_result_capture

---
 rtl/dsp_result_capture.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dsp_result_capture.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dsp_result_capture                                              |
// | Purpose  : Tracks DSP pipeline latency with a valid shift register. It      |
// |            captures {CARRYOUT,P} into a credit-managed result FIFO.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dsp_result_capture #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4,
  parameter int PW      = 48
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [PW-1:0] P,
  input  logic          CARRYOUT,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_p,
  output logic          out_carry,
  output logic          overflow,
  output logic [7:0]    drop_count
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_OW = c_AW + 1;
  localparam int c_IW = $clog2(LATENCY + 1);
  localparam int c_SW = 6;

  localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
  localparam logic [c_OW-1:0] c_OCC_ONE = c_OW'(1);
  localparam logic [c_OW-1:0] c_OCC_MAX = c_OW'(DEPTH);
  localparam logic [c_IW-1:0] c_INF_ONE = c_IW'(1);
  localparam logic [c_SW-1:0] c_CREDITS = c_SW'(DEPTH);

  logic [LATENCY-1:0] r_vsr;
  logic [c_IW-1:0]    r_inflight;
  logic [c_AW-1:0]    r_wptr;
  logic [c_AW-1:0]    r_rptr;
  logic [c_OW-1:0]    r_occ;
  logic               r_overflow;
  logic [7:0]         r_drops;
  logic [PW:0]        r_mem [DEPTH];

  logic               w_capture;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [c_SW-1:0]    w_load;
  logic [PW:0]        w_head;

  // The bit leaving the last stage marks the cycle in which P is valid.
  assign w_capture = r_vsr[LATENCY-1];
  assign w_full    = (r_occ == c_OCC_MAX);
  assign out_valid = (r_occ != '0);
  assign w_pop     = out_valid && out_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign w_push    = w_capture && (!w_full || w_pop);
  assign w_drop    = w_capture && w_full && !w_pop;

  assign w_load      = c_SW'(r_inflight) + c_SW'(r_occ);
  assign issue_ready = (w_load < c_CREDITS);

  assign w_head     = r_mem[r_rptr];
  assign out_p      = out_valid ? w_head[PW-1:0] : '0;
  assign out_carry  = out_valid ? w_head[PW] : 1'b0;
  assign overflow   = r_overflow;
  assign drop_count = r_drops;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_vsr <= '0;
    end else begin
      r_vsr[0] <= issue_valid;
      for (int i = 1; i < LATENCY; i++) begin
        r_vsr[i] <= r_vsr[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_inflight <= '0;
    end else if (issue_valid && !w_capture) begin
      r_inflight <= r_inflight + c_INF_ONE;
    end else if (!issue_valid && w_capture) begin
      r_inflight <= r_inflight - c_INF_ONE;
    end
  end

  // Storage carries no reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {CARRYOUT, P};
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + c_OCC_ONE;
      end else if (w_pop && !w_push) begin
        r_occ <= r_occ - c_OCC_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_overflow <= 1'b0;
      r_drops    <= 8'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drops != 8'hFF) begin
        r_drops <= r_drops + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire
